regs_bank: RTL and testbench
============================

Name: regs_bank

Overview:
- Parametrised control/status register bank, the successor of the fixed 16-entry register core.
- Adds a configurable register count and per-bit write masking.
- Adds sticky status bits (set by user logic, write-1-to-clear by the bus) and a key-protected write lock.
- Adds a registered bus response with ACK/ERR and a registered interrupt summary.
- Sits between the UART command decoder (bus master) and the display/NTSC datapath (consumers of REGss_o).

Parameters:
- C_DAT_W, 8: register width in bits.
- C_ADR_W, 4: bus address width.
- C_REGS, 15: number of implemented registers, addresses 0..C_REGS-1; must be ≤ 2**C_ADR_W-1.
- C_USEss, all ones: per-bit implemented mask, C_REGS*C_DAT_W bits, register a at slice a.
- C_DEFAULTss, 0: per-bit reset value, same layout.
- C_W1Css, 0: per-bit sticky-status mask, same layout; only meaningful where C_USEss=1.
- C_PROTs, 0: C_REGS bits; bit a=1 means register a is write-protected while locked.
- C_LOCK_ADR, 2**C_ADR_W-1: address of the lock register.
- C_KEY, 8'hA5: unlock key, C_DAT_W bits.

Ports:
- CK_i, in, 1: clock.
- XARST_i, in, 1: reset.
- RST_i, in, 1: synchronous soft reset of register contents to defaults.
- REQ_i, in, 1: bus request, one transfer per cycle.
- WT_i, in, 1: 1 = write, 0 = read; qualified by REQ_i.
- ADRs_i, in, C_ADR_W: address.
- WDATs_i, in, C_DAT_W: write data.
- WMSKs_i, in, C_DAT_W: per-bit write enable.
- USR_WDATss_i, in, C_REGS*C_DAT_W: user write data.
- USR_WTss_i, in, C_REGS*C_DAT_W: user per-bit write strobes (RW bits only).
- USR_SETss_i, in, C_REGS*C_DAT_W: sticky-bit set pulses (W1C bits only).
- RDATss_i, in, C_REGS*C_DAT_W: external read-only values (unused bits only).
- REGss_o, out, C_REGS*C_DAT_W: current register contents.
- ACK_o, out, 1: transfer response.
- ERR_o, out, 1: response error, valid with ACK_o.
- RDATs_o, out, C_DAT_W: read data, valid with ACK_o.
- LOCKED_o, out, 1: lock state.
- IRQ_o, out, 1: OR of all sticky bits.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low. XARST_i is sampled on rising CK_i; there is no asynchronous path.
- XARST_i=0 at an edge sets:
  - registers to C_DEFAULTss;
  - LOCKED_o=0, ACK_o=0, ERR_o=0, RDATs_o=0, IRQ_o=0.
  - A transfer in flight at reset is dropped with no ACK.
- Unused bits (C_USEss=0):
  - REGss_o = default.
  - Read returns default | RDATss_i bit.
  - Writes are ignored.
- RW bits (used, not W1C): per-edge priority, highest first:
  1. Bus write with hit and mask bit set, not blocked by lock.
  2. RST_i.
  3. USR_WTss_i strobe.
  4. Hold.
- W1C bits: per-edge priority, highest first:
  1. RST_i: bit = default.
  2. USR_SETss_i=1: bit = 1. Set wins over a same-cycle bus clear.
  3. Bus write with hit, mask=1 and data=1: bit = 0.
  4. Hold.
- Response timing:
  - REQ_i accepted every cycle, no stall.
  - ACK_o pulses exactly one cycle after each REQ_i; back-to-back REQ gives continuous ACK.
  - RDATs_o and ERR_o are registered with ACK_o; when ACK_o=0, RDATs_o=0 and ERR_o=0.
  - Read data is the pre-edge value: a read in the same cycle as a user update returns the old value.
- Lock register (C_LOCK_ADR):
  - Read returns {0…, LOCKED_o}, ERR=0.
  - Write with WDATs_i==C_KEY clears the lock.
  - Otherwise a write with WDATs_i[0]=1 sets the lock; a write with bit0=0 and a non-key value has no effect.
  - WMSKs_i is ignored for this register.
- Protection: a write to register a with LOCKED_o=1 and C_PROTs[a]=1 changes nothing and returns ERR=1. Reads are never blocked.
- Address range: an address ≥ C_REGS and ≠ C_LOCK_ADR returns ACK with ERR=1 and RDATs=0, with no state change.
- IRQ_o is registered, one cycle after a sticky bit changes.
- RST_i does not affect the lock, ACK, ERR or an in-flight response.

Test Plan:
- Reset: hold XARST_i=0 for 3 cycles with C_DEFAULTss reg2=8'h3C → REGss_o slice2=8'h3C, ACK_o=0, LOCKED_o=0. A read of address 2 afterwards → ACK next cycle with RDATs_o=8'h3C.
- Masked write: write address 1, WDATs=8'hFF, WMSKs=8'h0F over a value of 8'h00 → reg1=8'h0F. The same-cycle USR_WT on bit 0 loses; a USR_WT alone on the next cycle wins.
- W1C: USR_SET bit3 of reg4 → IRQ_o=1 one cycle later. Write 8'h08 to address 4 in the same cycle as USR_SET bit3 → bit stays 1. Write 8'h08 alone → bit 0, IRQ_o=0.
- Lock: write 8'h01 to C_LOCK_ADR → LOCKED_o=1. Write to protected reg5 → ACK+ERR, reg5 unchanged; write to unprotected reg6 succeeds. Write 8'hA5 to C_LOCK_ADR → LOCKED_o=0.
- Range/throughput: 4 back-to-back REQs (read 0, read 15 with C_REGS=14, write 14, read 0) → 4 consecutive ACKs. ERR pattern is 0,0,1,0 (read 15 is the lock register, write 14 is out of range).
- Reset mid-transfer: assert XARST_i=0 in the cycle after a REQ → no ACK, all outputs return to their reset values.

Source files
------------

// File: rtl/regs_bank.sv
// regs_bank: parametrised control/status register bank.
// Masked RW bits, sticky W1C bits, key lock, registered response.
module regs_bank #(
  parameter int C_DAT_W = 8,
  parameter int C_ADR_W = 4,
  parameter int C_REGS  = 15,
  parameter logic [C_REGS*C_DAT_W-1:0] C_USEss     = '1,
  parameter logic [C_REGS*C_DAT_W-1:0] C_DEFAULTss = '0,
  parameter logic [C_REGS*C_DAT_W-1:0] C_W1Css     = '0,
  parameter logic [C_REGS-1:0]         C_PROTs     = '0,
  parameter logic [C_ADR_W-1:0]        C_LOCK_ADR  = '1,
  parameter logic [C_DAT_W-1:0]        C_KEY       = C_DAT_W'(8'hA5)
) (
  input  logic                      CK_i,
  input  logic                      XARST_i,
  input  logic                      RST_i,
  input  logic                      REQ_i,
  input  logic                      WT_i,
  input  logic [C_ADR_W-1:0]        ADRs_i,
  input  logic [C_DAT_W-1:0]        WDATs_i,
  input  logic [C_DAT_W-1:0]        WMSKs_i,
  input  logic [C_REGS*C_DAT_W-1:0] USR_WDATss_i,
  input  logic [C_REGS*C_DAT_W-1:0] USR_WTss_i,
  input  logic [C_REGS*C_DAT_W-1:0] USR_SETss_i,
  input  logic [C_REGS*C_DAT_W-1:0] RDATss_i,
  output logic [C_REGS*C_DAT_W-1:0] REGss_o,
  output logic                      ACK_o,
  output logic                      ERR_o,
  output logic [C_DAT_W-1:0]        RDATs_o,
  output logic                      LOCKED_o,
  output logic                      IRQ_o
);

  localparam int NB = C_REGS * C_DAT_W;
  localparam logic [C_ADR_W:0] REGS_A = (C_ADR_W + 1)'(C_REGS);
  localparam logic [NB-1:0] STICKY = C_W1Css & C_USEss;

  logic [NB-1:0]      regs_q;
  logic [NB-1:0]      regs_d;
  logic [NB-1:0]      view;
  logic [C_REGS-1:0]  hit;
  logic [C_REGS-1:0]  wen;
  logic               wr;
  logic               lock_hit;
  logic               in_range;
  logic               blocked;
  logic [C_DAT_W-1:0] rd_word;
  logic               rsp_err;
  logic [C_DAT_W-1:0] rsp_dat;
  logic               locked_q;
  logic               locked_d;
  logic               ack_q;
  logic               err_q;
  logic [C_DAT_W-1:0] rdat_q;
  logic               irq_q;

  assign wr       = REQ_i & WT_i;
  assign lock_hit = (ADRs_i == C_LOCK_ADR);
  assign in_range = ({1'b0, ADRs_i} < REGS_A);

  // Address decode: one-hot register hit, lock-protection gate
  always_comb begin
    hit = '0;
    for (int a = 0; a < C_REGS; a++) begin
      hit[a] = wr && !lock_hit && (ADRs_i == C_ADR_W'(a));
    end
    blocked = locked_q && |(hit & C_PROTs);
    wen     = blocked ? '0 : hit;
  end

  // Per-bit next value; unused bits are pinned to their default
  always_comb begin
    regs_d = regs_q;
    for (int a = 0; a < C_REGS; a++) begin
      for (int b = 0; b < C_DAT_W; b++) begin
        if (!C_USEss[a*C_DAT_W+b]) begin
          regs_d[a*C_DAT_W+b] = C_DEFAULTss[a*C_DAT_W+b];
        end else if (C_W1Css[a*C_DAT_W+b]) begin
          if (RST_i) begin
            regs_d[a*C_DAT_W+b] = C_DEFAULTss[a*C_DAT_W+b];
          end else if (USR_SETss_i[a*C_DAT_W+b]) begin
            regs_d[a*C_DAT_W+b] = 1'b1;
          end else if (wen[a] && WMSKs_i[b] && WDATs_i[b]) begin
            regs_d[a*C_DAT_W+b] = 1'b0;
          end
        end else begin
          if (wen[a] && WMSKs_i[b]) begin
            regs_d[a*C_DAT_W+b] = WDATs_i[b];
          end else if (RST_i) begin
            regs_d[a*C_DAT_W+b] = C_DEFAULTss[a*C_DAT_W+b];
          end else if (USR_WTss_i[a*C_DAT_W+b]) begin
            regs_d[a*C_DAT_W+b] = USR_WDATss_i[a*C_DAT_W+b];
          end
        end
      end
    end
  end

  // Read view: unused bits show default ORed with external status
  always_comb begin
    view    = regs_q | (~C_USEss & RDATss_i);
    rd_word = '0;
    for (int a = 0; a < C_REGS; a++) begin
      if (ADRs_i == C_ADR_W'(a)) begin
        rd_word = view[a*C_DAT_W +: C_DAT_W];
      end
    end
  end

  // Response payload and lock next state
  always_comb begin
    rsp_err  = 1'b0;
    rsp_dat  = '0;
    locked_d = locked_q;
    if (REQ_i) begin
      unique case (1'b1)
        lock_hit: begin
          if (!WT_i) begin
            rsp_dat = {{(C_DAT_W-1){1'b0}}, locked_q};
          end else if (WDATs_i == C_KEY) begin
            locked_d = 1'b0;
          end else if (WDATs_i[0]) begin
            locked_d = 1'b1;
          end
        end
        in_range: begin
          rsp_err = WT_i & blocked;
          rsp_dat = WT_i ? '0 : rd_word;
        end
        default: begin
          rsp_err = 1'b1;
        end
      endcase
    end
  end

  // Register storage
  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      regs_q <= C_DEFAULTss;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Lock state, bus response and interrupt summary
  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      locked_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdat_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      locked_q <= locked_d;
      ack_q    <= REQ_i;
      err_q    <= rsp_err;
      rdat_q   <= rsp_dat;
      irq_q    <= |(regs_q & STICKY);
    end
  end

  assign REGss_o  = regs_q;
  assign ACK_o    = ack_q;
  assign ERR_o    = err_q;
  assign RDATs_o  = rdat_q;
  assign LOCKED_o = locked_q;
  assign IRQ_o    = irq_q;

endmodule

// File: tb/tb_regs_bank.sv
// tb_regs_bank: directed plan plus random traffic
// checked against a word-level reference model.
module tb_regs_bank;

  localparam int NR = 14;
  localparam int NB = NR * 8;

  function automatic logic [NB-1:0] put(int a, logic [7:0] v);
    logic [NB-1:0] r;
    r = '0;
    r[a*8 +: 8] = v;
    return r;
  endfunction

  localparam logic [NB-1:0] USE = ~put(7, 8'hF0);
  localparam logic [NB-1:0] DEF = put(2, 8'h3C) | put(7, 8'hA0);
  localparam logic [NB-1:0] W1C = put(4, 8'h0F) | put(9, 8'hF0);
  localparam logic [NR-1:0] PROT = 14'b00_0010_0010_0000;
  localparam logic [7:0]    KEY = 8'hA5;

  logic          clk = 1'b0;
  logic          xarst, rst, req, wt;
  logic [3:0]    adr;
  logic [7:0]    wdat, wmsk;
  logic [NB-1:0] usr_wdat, usr_wt, usr_set, rdat_ext;
  logic [NB-1:0] regs;
  logic          ack, err, locked, irq;
  logic [7:0]    rdat;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] m_reg [NR];
  logic       m_lock;
  logic       e_ack, e_err, e_irq;
  logic [7:0] e_rdat;

  regs_bank #(
    .C_DAT_W(8), .C_ADR_W(4), .C_REGS(NR),
    .C_USEss(USE), .C_DEFAULTss(DEF), .C_W1Css(W1C),
    .C_PROTs(PROT), .C_LOCK_ADR(4'hF), .C_KEY(KEY)
  ) dut (
    .CK_i(clk), .XARST_i(xarst), .RST_i(rst),
    .REQ_i(req), .WT_i(wt), .ADRs_i(adr),
    .WDATs_i(wdat), .WMSKs_i(wmsk),
    .USR_WDATss_i(usr_wdat), .USR_WTss_i(usr_wt),
    .USR_SETss_i(usr_set), .RDATss_i(rdat_ext),
    .REGss_o(regs), .ACK_o(ack), .ERR_o(err),
    .RDATs_o(rdat), .LOCKED_o(locked), .IRQ_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] pack();
    logic [NB-1:0] r;
    for (int a = 0; a < NR; a++) r[a*8 +: 8] = m_reg[a];
    return r;
  endfunction

  // Reference: what one clock edge does, from the pre-edge state
  task automatic model();
    logic [7:0] nx [NR];
    logic [7:0] u, s, d, base, rwv, clr, w1v, uwt, uwd, st;
    logic blk;
    if (!xarst) begin
      for (int a = 0; a < NR; a++) m_reg[a] = DEF[a*8 +: 8];
      m_lock = 0; e_ack = 0; e_err = 0; e_rdat = 0; e_irq = 0;
      return;
    end
    blk = 0;
    e_ack = req; e_err = 0; e_rdat = 0;
    e_irq = |(pack() & W1C & USE);
    if (req) begin
      if (adr == 4'hF) begin
        if (!wt) e_rdat = {7'b0, m_lock};
      end else if (adr < NR) begin
        if (wt) begin
          blk = m_lock && PROT[adr];
          e_err = blk;
        end else begin
          u = USE[adr*8 +: 8];
          e_rdat = (m_reg[adr] & u) |
                   (~u & (DEF[adr*8 +: 8] | rdat_ext[adr*8 +: 8]));
        end
      end else begin
        e_err = 1;
      end
    end
    for (int a = 0; a < NR; a++) begin
      logic wen;
      u = USE[a*8 +: 8];
      s = W1C[a*8 +: 8] & u;
      d = DEF[a*8 +: 8];
      uwt = usr_wt[a*8 +: 8];
      uwd = usr_wdat[a*8 +: 8];
      st = usr_set[a*8 +: 8];
      wen = req && wt && (adr == 4'(a)) && !blk;
      base = rst ? d : ((m_reg[a] & ~uwt) | (uwd & uwt));
      rwv = wen ? ((base & ~wmsk) | (wdat & wmsk)) : base;
      clr = wen ? (wmsk & wdat) : 8'h00;
      w1v = rst ? d : ((m_reg[a] & ~clr) | st);
      nx[a] = (rwv & u & ~s) | (w1v & s) | (d & ~u);
    end
    for (int a = 0; a < NR; a++) m_reg[a] = nx[a];
    if (req && wt && adr == 4'hF) begin
      if (wdat == KEY) m_lock = 0;
      else if (wdat[0]) m_lock = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check("regs", 128'(regs), 128'(pack()));
    check("ack", 128'(ack), 128'(e_ack));
    check("err", 128'(err), 128'(e_err));
    check("rdat", 128'(rdat), 128'(e_rdat));
    check("locked", 128'(locked), 128'(m_lock));
    check("irq", 128'(irq), 128'(e_irq));
  endtask

  task automatic idle();
    xarst = 1; rst = 0; req = 0; wt = 0; adr = 0;
    wdat = 0; wmsk = 0; usr_wdat = '0; usr_wt = '0;
    usr_set = '0; rdat_ext = '0;
  endtask

  task automatic bus(logic w, logic [3:0] a, logic [7:0] dv, logic [7:0] mv);
    req = 1; wt = w; adr = a; wdat = dv; wmsk = mv;
  endtask

  initial begin
    logic [3:0] errs;
    idle();
    xarst = 0;
    repeat (3) step();
    xarst = 1;
    check("rst_reg2", 128'(regs[16 +: 8]), 128'(8'h3C));
    check("rst_ack", 128'(ack), 128'(0));
    check("rst_lock", 128'(locked), 128'(0));

    bus(0, 2, 0, 0); step(); idle();
    check("rd2_ack", 128'(ack), 128'(1));
    check("rd2_dat", 128'(rdat), 128'(8'h3C));

    bus(1, 1, 8'hFF, 8'h0F);
    usr_wt[8] = 1; usr_wdat[8] = 0;
    step(); idle();
    check("mw_reg1", 128'(regs[8 +: 8]), 128'(8'h0F));
    usr_wt[8] = 1; usr_wdat[8] = 0;
    step(); idle();
    check("uw_reg1", 128'(regs[8 +: 8]), 128'(8'h0E));

    usr_set[35] = 1; step(); idle();
    check("w1c_set", 128'(regs[35]), 128'(1));
    step();
    check("irq_on", 128'(irq), 128'(1));
    bus(1, 4, 8'h08, 8'hFF); usr_set[35] = 1; step(); idle();
    check("w1c_race", 128'(regs[35]), 128'(1));
    bus(1, 4, 8'h08, 8'hFF); step(); idle();
    check("w1c_clr", 128'(regs[35]), 128'(0));
    step();
    check("irq_off", 128'(irq), 128'(0));

    bus(1, 15, 8'h01, 8'h00); step(); idle();
    check("lock_on", 128'(locked), 128'(1));
    bus(1, 5, 8'h55, 8'hFF); step(); idle();
    check("prot_err", 128'(err), 128'(1));
    check("prot_reg5", 128'(regs[40 +: 8]), 128'(8'h00));
    bus(1, 6, 8'h66, 8'hFF); step(); idle();
    check("unprot_reg6", 128'(regs[48 +: 8]), 128'(8'h66));
    bus(1, 15, KEY, 8'h00); step(); idle();
    check("lock_off", 128'(locked), 128'(0));

    errs = '0;
    bus(0, 0, 0, 0); step(); errs[0] = err; check("b2b_ack0", 128'(ack), 128'(1));
    bus(0, 15, 0, 0); step(); errs[1] = err; check("b2b_ack1", 128'(ack), 128'(1));
    bus(1, 14, 8'h77, 8'hFF); step(); errs[2] = err; check("b2b_ack2", 128'(ack), 128'(1));
    bus(0, 0, 0, 0); step(); errs[3] = err; check("b2b_ack3", 128'(ack), 128'(1));
    idle();
    check("b2b_err", 128'(errs), 128'(4'b0100));

    bus(1, 15, 8'h01, 8'h00); step(); idle();
    bus(0, 2, 0, 0); step(); idle();
    xarst = 0; step();
    check("mid_ack", 128'(ack), 128'(0));
    check("mid_lock", 128'(locked), 128'(0));
    check("mid_regs", 128'(regs), 128'(DEF));
    idle();
    bus(0, 3, 0, 0); xarst = 0; step(); idle();
    check("drop_ack", 128'(ack), 128'(0));

    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 3) != 0);
      wt = 1'($urandom);
      adr = 4'($urandom);
      wdat = ($urandom_range(0, 7) == 0) ? KEY : 8'($urandom);
      wmsk = 8'($urandom);
      for (int a = 0; a < NR; a++) begin
        usr_wdat[a*8 +: 8] = 8'($urandom);
        usr_wt[a*8 +: 8] = 8'($urandom & $urandom & $urandom);
        usr_set[a*8 +: 8] = 8'($urandom & $urandom & $urandom & $urandom);
        rdat_ext[a*8 +: 8] = 8'($urandom);
      end
      rst = ($urandom_range(0, 31) == 0);
      xarst = ($urandom_range(0, 99) != 0);
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
